// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcodes, ALU function selects, control-word layout and FSM states shared by the
// control sequencer. Build option CU_SWAP_EN adds the SWAP opcode and its third step state.
package cu_pkg;

    typedef enum logic [3:0] {
        OP_MOV  = 4'h0,
        OP_INC  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_DEC  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_NOT  = 4'h8,
        OP_ADDI = 4'h9,
        OP_LD   = 4'hA,
        OP_SWAP = 4'hB,
        OP_LDI  = 4'hC
    } op_e;

    // FS = {Cin, S2, S1, S0}
    localparam logic [3:0] FS_MOV = 4'b0000;
    localparam logic [3:0] FS_INC = 4'b1000;
    localparam logic [3:0] FS_ADD = 4'b0001;
    localparam logic [3:0] FS_SUB = 4'b1010;
    localparam logic [3:0] FS_DEC = 4'b0011;
    localparam logic [3:0] FS_AND = 4'b0100;
    localparam logic [3:0] FS_OR  = 4'b0101;
    localparam logic [3:0] FS_XOR = 4'b0110;
    localparam logic [3:0] FS_NOT = 4'b0111;

    localparam int CW_RW = 12;
    localparam int CW_MD = 11;
    localparam int CW_FS = 7;
    localparam int CW_MB = 6;
    localparam int CW_BA = 4;
    localparam int CW_AA = 2;
    localparam int CW_DA = 0;

    // Encoding doubles as the micro-step index (0 = first step) fed to the encoder.
`ifdef CU_SWAP_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_S2 = 2'd1, ST_S3 = 2'd2} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_S2 = 2'd1} state_e;
`endif

    function automatic logic [12:0] cw_pack(input logic rw, input logic md, input logic [3:0] fs,
                                             input logic mb, input logic [1:0] ba, input logic [1:0] aa,
                                             input logic [1:0] da);
        logic [12:0] w;
        w = '0;
        w[CW_RW]        = rw;
        w[CW_MD]        = md;
        w[CW_FS +: 4]   = fs;
        w[CW_MB]        = mb;
        w[CW_BA +: 2]   = ba;
        w[CW_AA +: 2]   = aa;
        w[CW_DA +: 2]   = da;
        return w;
    endfunction

endpackage

// File: rtl/control_sequencer_cw_encoder.sv
// cw_encoder: maps one micro-step of an instruction to its control word, constant operand and illegal flag.
// SWAP decoding exists only when CU_SWAP_EN is defined; otherwise opcode B falls into the illegal default.
module cw_encoder
    import cu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  step_i,
    input  logic [1:0]  dr_i,
    input  logic [1:0]  sa_i,
    input  logic [1:0]  sb_i,
    input  logic [3:0]  imm_i,
    output logic [12:0] cw_o,
    output logic [3:0]  const_o,
    output logic        illegal_o
);

    op_e op;
    assign op = op_e'(op_i);

    // Decode opcode and step into a datapath control word; unknown opcodes produce a NOP and flag illegal.
    always_comb begin
        cw_o      = '0;
        const_o   = '0;
        illegal_o = 1'b0;
        case (op)
            OP_MOV:  cw_o = cw_pack(1'b1, 1'b0, FS_MOV, 1'b0, sb_i, sa_i, dr_i);
            OP_INC:  cw_o = cw_pack(1'b1, 1'b0, FS_INC, 1'b0, sb_i, sa_i, dr_i);
            OP_ADD:  cw_o = cw_pack(1'b1, 1'b0, FS_ADD, 1'b0, sb_i, sa_i, dr_i);
            OP_SUB:  cw_o = cw_pack(1'b1, 1'b0, FS_SUB, 1'b0, sb_i, sa_i, dr_i);
            OP_DEC:  cw_o = cw_pack(1'b1, 1'b0, FS_DEC, 1'b0, sb_i, sa_i, dr_i);
            OP_AND:  cw_o = cw_pack(1'b1, 1'b0, FS_AND, 1'b0, sb_i, sa_i, dr_i);
            OP_OR:   cw_o = cw_pack(1'b1, 1'b0, FS_OR,  1'b0, sb_i, sa_i, dr_i);
            OP_XOR:  cw_o = cw_pack(1'b1, 1'b0, FS_XOR, 1'b0, sb_i, sa_i, dr_i);
            OP_NOT:  cw_o = cw_pack(1'b1, 1'b0, FS_NOT, 1'b0, sb_i, sa_i, dr_i);
            OP_ADDI: begin
                cw_o    = cw_pack(1'b1, 1'b0, FS_ADD, 1'b1, sb_i, sa_i, dr_i);
                const_o = imm_i;
            end
            OP_LD:   cw_o = cw_pack(1'b1, 1'b1, 4'b0000, 1'b0, 2'b00, 2'b00, dr_i);
`ifdef CU_SWAP_EN
            // XOR swap: SA^=SB, SB^=SA, SA^=SB; identical registers need no work.
            OP_SWAP: if (sa_i != sb_i)
                cw_o = step_i == 2'd1 ? cw_pack(1'b1, 1'b0, FS_XOR, 1'b0, sa_i, sb_i, sb_i)
                                      : cw_pack(1'b1, 1'b0, FS_XOR, 1'b0, sb_i, sa_i, sa_i);
`endif
            // Clear DR with a self-XOR, then add the immediate to it.
            OP_LDI:  begin
                cw_o    = step_i == 2'd0 ? cw_pack(1'b1, 1'b0, FS_XOR, 1'b0, dr_i, dr_i, dr_i)
                                         : cw_pack(1'b1, 1'b0, FS_ADD, 1'b1, dr_i, dr_i, dr_i);
                const_o = step_i == 2'd0 ? 4'h0 : imm_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: accepts one instruction per valid/ready handshake and issues one registered control
// word per clock, expanding LDI (and SWAP when CU_SWAP_EN is defined) into consecutive micro-steps.
module control_sequencer
    import cu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        instr_valid,
    input  logic [13:0] instr,
    output logic        instr_ready,
    output logic [12:0] ControlWord,
    output logic [3:0]  ConstantOut,
    output logic        busy,
    output logic        illegal
);

    state_e      state_q;
    logic [13:0] instr_q;
    logic [12:0] cw_q;
    logic [3:0]  const_q;
    logic        illegal_q;
    logic        busy_q;
    logic        idle;
    logic        multi;
    logic [1:0]  step;
    logic [13:0] cur;
    op_e         cur_op;
    logic [12:0] enc_cw;
    logic [3:0]  enc_const;
    logic        enc_illegal;

    // In IDLE the live instruction is decoded; later steps use the copy latched at acceptance.
    assign idle   = state_q == ST_IDLE;
    assign cur    = idle ? instr : instr_q;
    assign cur_op = op_e'(cur[13:10]);
    assign step   = state_q;
`ifdef CU_SWAP_EN
    assign multi  = cur_op == OP_LDI || (cur_op == OP_SWAP && cur[7:6] != cur[5:4]);
`else
    assign multi  = cur_op == OP_LDI;
`endif

    cw_encoder u_enc (
        .op_i      (cur[13:10]),
        .step_i    (step),
        .dr_i      (cur[9:8]),
        .sa_i      (cur[7:6]),
        .sb_i      (cur[5:4]),
        .imm_i     (cur[3:0]),
        .cw_o      (enc_cw),
        .const_o   (enc_const),
        .illegal_o (enc_illegal)
    );

    // Step FSM and output registers; any cycle without an issued step presents a NOP.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            cw_q      <= '0;
            const_q   <= '0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cw_q      <= '0;
            const_q   <= '0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            case (state_q)
                ST_IDLE: if (instr_valid) begin
                    instr_q   <= instr;
                    cw_q      <= enc_cw;
                    const_q   <= enc_const;
                    illegal_q <= enc_illegal;
                    state_q   <= multi ? ST_S2 : ST_IDLE;
                end
                ST_S2: begin
                    cw_q    <= enc_cw;
                    const_q <= enc_const;
                    busy_q  <= 1'b1;
`ifdef CU_SWAP_EN
                    state_q <= op_e'(instr_q[13:10]) == OP_SWAP ? ST_S3 : ST_IDLE;
`else
                    state_q <= ST_IDLE;
`endif
                end
`ifdef CU_SWAP_EN
                ST_S3: begin
                    cw_q    <= enc_cw;
                    const_q <= enc_const;
                    busy_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = idle;
    assign ControlWord = cw_q;
    assign ConstantOut = const_q;
    assign illegal     = illegal_q;
    assign busy        = busy_q;

endmodule
